pipeline_ctrl: RTL and testbench



---
 rtl/pipeline_ctrl_pkg.sv | 33 +++
 rtl/pipe_perf_cnt.sv | 26 ++
 rtl/pipeline_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for pipeline_ctrl: decode exception bit indices, FSM states, trap causes.
// Pure definitions, no timing; includes the lowest-set-bit cause priority helper.
package pipeline_ctrl_pkg;

  localparam int ILLEGAL         = 0;
  localparam int ECALL           = 1;
  localparam int EBREAK          = 2;
  localparam int MRET            = 3;
  localparam int EXCEPTION_WIDTH = 4;

  typedef enum logic [2:0] {
    PC_RUN      = 3'd0,
    PC_MEM_WAIT = 3'd1,
    PC_DRAIN    = 3'd2,
    PC_TRAP     = 3'd3,
    PC_HALT     = 3'd4
  } pc_state_e;

  typedef enum logic [1:0] {
    CAUSE_ILLEGAL = 2'd0,
    CAUSE_ECALL   = 2'd1,
    CAUSE_EBREAK  = 2'd2,
    CAUSE_MRET    = 2'd3
  } cause_e;

  function automatic cause_e exc_to_cause(input logic [EXCEPTION_WIDTH-1:0] exc);
    if (exc[ILLEGAL])     return CAUSE_ILLEGAL;
    else if (exc[ECALL])  return CAUSE_ECALL;
    else if (exc[EBREAK]) return CAUSE_EBREAK;
    else                  return CAUSE_MRET;
  endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Three free-running 32-bit wrapping event counters (stall cycles, redirects, trap entries).
// Counts on the edge after the event; no backpressure, counters never saturate.
module pipe_perf_cnt (
  input  logic        p_clk,
  input  logic        p_rst,
  input  logic        stall_evt,
  input  logic        flush_evt,
  input  logic        trap_evt,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_flush,
  output logic [31:0] perf_trap
);

  always_ff @(posedge p_clk) begin
    if (p_rst) begin
      perf_stall <= '0;
      perf_flush <= '0;
      perf_trap  <= '0;
    end else begin
      if (stall_evt) perf_stall <= perf_stall + 32'd1;
      if (flush_evt) perf_flush <= perf_flush + 32'd1;
      if (trap_evt)  perf_trap  <= perf_trap + 32'd1;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/trap sequencer for the 5-stage pipeline; stall/flush/redirect are same-cycle (Mealy), mepc/cause/halted registered.
// mem_busy stalls every stage and freezes trap sequencing; PIPE_CTRL_PERF_EN adds performance counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int                 AWIDTH       = 5,
  parameter int                 PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0] TRAP_VECTOR = 32'h0000_0100,
  parameter int                 DRAIN_CYCLES = 3
) (
  input  logic                       p_clk,
  input  logic                       p_rst,
  input  logic                       p_i_dec_ce,
  input  logic [AWIDTH-1:0]          p_i_dec_rs1,
  input  logic [AWIDTH-1:0]          p_i_dec_rs2,
  input  logic [EXCEPTION_WIDTH-1:0] p_i_dec_exception,
  input  logic [PC_WIDTH-1:0]        p_i_dec_pc,
  input  logic                       p_i_ex_ce,
  input  logic                       p_i_ex_load,
  input  logic [AWIDTH-1:0]          p_i_ex_rd,
  input  logic                       p_i_ex_redirect,
  input  logic [PC_WIDTH-1:0]        p_i_ex_target,
  input  logic                       p_i_mem_busy,
  input  logic                       p_i_resume,
  output logic                       p_o_stall_fetch,
  output logic                       p_o_stall_decode,
  output logic                       p_o_stall_execute,
  output logic                       p_o_flush_decode,
  output logic                       p_o_flush_execute,
  output logic                       p_o_redirect,
  output logic [PC_WIDTH-1:0]        p_o_redirect_pc,
  output logic [PC_WIDTH-1:0]        p_o_mepc,
  output logic [1:0]                 p_o_cause,
  output logic                       p_o_halted
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]                p_o_perf_stall,
  output logic [31:0]                p_o_perf_flush,
  output logic [31:0]                p_o_perf_trap
`endif
);

  pc_state_e           state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [PC_WIDTH-1:0] mepc_q, mepc_d;
  cause_e              cause_q, cause_d;
  logic                redirect_q;

  logic                stall_f, stall_d, stall_e, flush_d, flush_e, redir;
  logic [PC_WIDTH-1:0] redir_pc;
  logic                load_use, ex_redir;

  assign load_use = p_i_ex_ce & p_i_ex_load & p_i_dec_ce & (p_i_ex_rd != '0) &
                    ((p_i_ex_rd == p_i_dec_rs1) | (p_i_ex_rd == p_i_dec_rs2));
  // The slot after any redirect holds a flushed instruction, so its redirect is stale.
  assign ex_redir = p_i_ex_redirect & ~redirect_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mepc_d   = mepc_q;
    cause_d  = cause_q;
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    stall_e  = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    redir    = 1'b0;
    redir_pc = '0;

    case (state_q)
      PC_RUN, PC_MEM_WAIT: begin
        if (p_i_mem_busy) begin
          state_d = PC_MEM_WAIT;
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
        end else begin
          state_d = PC_RUN;
          if (ex_redir) begin
            flush_d  = 1'b1;
            redir    = 1'b1;
            redir_pc = p_i_ex_target;
          end else if (p_i_dec_ce && (p_i_dec_exception != '0)) begin
            mepc_d  = p_i_dec_pc;
            cause_d = exc_to_cause(p_i_dec_exception);
            cnt_d   = 4'(DRAIN_CYCLES);
            state_d = (DRAIN_CYCLES <= 1) ? PC_TRAP : PC_DRAIN;
          end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
          end
        end
      end
      PC_DRAIN: begin
        stall_f = 1'b1;
        flush_d = 1'b1;
        if (p_i_mem_busy) begin
          stall_d = 1'b1;
          stall_e = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd2) state_d = PC_TRAP;
        end
      end
      PC_TRAP: begin
        case (cause_q)
          CAUSE_EBREAK: state_d = PC_HALT;
          CAUSE_MRET: begin
            redir    = 1'b1;
            redir_pc = mepc_q + PC_WIDTH'(4);
            state_d  = PC_RUN;
          end
          default: begin
            redir    = 1'b1;
            redir_pc = TRAP_VECTOR;
            state_d  = PC_RUN;
          end
        endcase
      end
      PC_HALT: begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = p_i_mem_busy;
        flush_d = 1'b1;
        if (p_i_resume) begin
          redir    = 1'b1;
          redir_pc = mepc_q + PC_WIDTH'(4);
          state_d  = PC_RUN;
        end
      end
      default: state_d = PC_RUN;
    endcase

    if (p_rst) begin
      stall_f  = 1'b0;
      stall_d  = 1'b0;
      stall_e  = 1'b0;
      flush_d  = 1'b0;
      flush_e  = 1'b0;
      redir    = 1'b0;
      redir_pc = '0;
    end
  end

  always_ff @(posedge p_clk) begin
    if (p_rst) begin
      state_q    <= PC_RUN;
      cnt_q      <= '0;
      mepc_q     <= '0;
      cause_q    <= CAUSE_ILLEGAL;
      redirect_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mepc_q     <= mepc_d;
      cause_q    <= cause_d;
      redirect_q <= redir;
    end
  end

  assign p_o_stall_fetch   = stall_f;
  assign p_o_stall_decode  = stall_d;
  assign p_o_stall_execute = stall_e;
  assign p_o_flush_decode  = flush_d;
  assign p_o_flush_execute = flush_e;
  assign p_o_redirect      = redir;
  assign p_o_redirect_pc   = redir_pc;
  assign p_o_mepc          = mepc_q;
  assign p_o_cause         = cause_q;
  assign p_o_halted        = (state_q == PC_HALT);

`ifdef PIPE_CTRL_PERF_EN
  pipe_perf_cnt u_perf (
    .p_clk      (p_clk),
    .p_rst      (p_rst),
    .stall_evt  (stall_f | stall_d | stall_e),
    .flush_evt  (redir),
    .trap_evt   (state_q == PC_TRAP),
    .perf_stall (p_o_perf_stall),
    .perf_flush (p_o_perf_flush),
    .perf_trap  (p_o_perf_trap)
  );
`else
  // Counters compiled out.
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl: table of single-cycle RUN vectors plus trap/halt/reset sequences.
module tb_pipeline_ctrl;

  logic        p_clk = 1'b0;
  logic        p_rst;
  logic        dec_ce;
  logic [4:0]  dec_rs1, dec_rs2;
  logic [3:0]  dec_exc;
  logic [31:0] dec_pc;
  logic        ex_ce, ex_load;
  logic [4:0]  ex_rd;
  logic        ex_redir;
  logic [31:0] ex_target;
  logic        mem_busy, resume;
  logic        stall_f, stall_d, stall_e, flush_d, flush_e, redir, halted;
  logic [31:0] redir_pc, mepc;
  logic [1:0]  cause;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall, perf_flush, perf_trap;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  pipeline_ctrl dut (
    .p_clk             (p_clk),
    .p_rst             (p_rst),
    .p_i_dec_ce        (dec_ce),
    .p_i_dec_rs1       (dec_rs1),
    .p_i_dec_rs2       (dec_rs2),
    .p_i_dec_exception (dec_exc),
    .p_i_dec_pc        (dec_pc),
    .p_i_ex_ce         (ex_ce),
    .p_i_ex_load       (ex_load),
    .p_i_ex_rd         (ex_rd),
    .p_i_ex_redirect   (ex_redir),
    .p_i_ex_target     (ex_target),
    .p_i_mem_busy      (mem_busy),
    .p_i_resume        (resume),
    .p_o_stall_fetch   (stall_f),
    .p_o_stall_decode  (stall_d),
    .p_o_stall_execute (stall_e),
    .p_o_flush_decode  (flush_d),
    .p_o_flush_execute (flush_e),
    .p_o_redirect      (redir),
    .p_o_redirect_pc   (redir_pc),
    .p_o_mepc          (mepc),
    .p_o_cause         (cause),
    .p_o_halted        (halted)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .p_o_perf_stall    (perf_stall),
    .p_o_perf_flush    (perf_flush),
    .p_o_perf_trap     (perf_trap)
`endif
  );

  always #5 p_clk = ~p_clk;

  typedef struct {
    logic        dec_ce;
    logic [4:0]  rs1, rs2;
    logic        ex_ce, ex_load;
    logic [4:0]  ex_rd;
    logic        ex_redir;
    logic [31:0] ex_target;
    logic        busy;
    logic [6:0]  exp_ctl;   // {stall_f, stall_d, stall_e, flush_d, flush_e, redirect, halted}
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input logic dce, input logic [4:0] r1, input logic [4:0] r2,
                              input logic ece, input logic eld, input logic [4:0] erd,
                              input logic erd_redir, input logic [31:0] tgt, input logic bsy,
                              input logic [6:0] ctl, input logic [31:0] pc);
    vec_t v;
    v.dec_ce = dce; v.rs1 = r1; v.rs2 = r2; v.ex_ce = ece; v.ex_load = eld; v.ex_rd = erd;
    v.ex_redir = erd_redir; v.ex_target = tgt; v.busy = bsy; v.exp_ctl = ctl; v.exp_pc = pc;
    return v;
  endfunction

  function automatic logic [6:0] ctl_now();
    return {stall_f, stall_d, stall_e, flush_d, flush_e, redir, halted};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge p_clk);
    #1;
  endtask

  task automatic idle_in();
    dec_ce = 0; dec_rs1 = 0; dec_rs2 = 0; dec_exc = 0; dec_pc = 0;
    ex_ce = 0; ex_load = 0; ex_rd = 0; ex_redir = 0; ex_target = 0;
    mem_busy = 0; resume = 0;
  endtask

  task automatic expect_cycle(input string name, input logic [6:0] ctl, input logic [31:0] pc);
    @(negedge p_clk);
    chk({name, ".ctl"}, 64'(ctl_now()), 64'(ctl));
    chk({name, ".pc"}, 64'(redir_pc), 64'(pc));
  endtask

  task automatic raise_exc(input logic [3:0] exc, input logic [31:0] pc);
    dec_ce = 1; dec_exc = exc; dec_pc = pc;
    @(negedge p_clk);
    chk("exc_cycle.redirect", 64'(redir), 64'(0));
    tick();
    idle_in();
  endtask

  localparam logic [6:0] C_IDLE  = 7'b000_0000;
  localparam logic [6:0] C_LU    = 7'b110_0100;
  localparam logic [6:0] C_BR    = 7'b000_1010;
  localparam logic [6:0] C_BUSY  = 7'b111_0000;
  localparam logic [6:0] C_DRAIN = 7'b100_1000;
  localparam logic [6:0] C_DBUSY = 7'b111_1000;
  localparam logic [6:0] C_RDIR  = 7'b000_0010;
  localparam logic [6:0] C_HALT  = 7'b110_1001;
  localparam logic [6:0] C_RESUM = 7'b110_1011;

  initial begin
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0,          0, C_IDLE, 0);
    vecs[1]  = mk(1, 3, 5, 1, 1, 5, 0, 0,          0, C_LU,   0);
    vecs[2]  = mk(1, 0, 0, 1, 1, 0, 0, 0,          0, C_IDLE, 0);
    vecs[3]  = mk(1, 7, 2, 1, 1, 7, 0, 0,          0, C_LU,   0);
    vecs[4]  = mk(1, 7, 2, 1, 0, 7, 0, 0,          0, C_IDLE, 0);
    vecs[5]  = mk(1, 7, 2, 0, 1, 7, 0, 0,          0, C_IDLE, 0);
    vecs[6]  = mk(0, 7, 2, 1, 1, 7, 0, 0,          0, C_IDLE, 0);
    vecs[7]  = mk(1, 5, 9, 1, 1, 5, 1, 32'h40,     0, C_BR,   32'h40);
    vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0,          0, C_IDLE, 0);
    vecs[9]  = mk(1, 4, 4, 1, 1, 4, 0, 0,          1, C_BUSY, 0);
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 1, 32'h80,     1, C_BUSY, 0);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 1, 32'h80,     0, C_BR,   32'h80);
    vecs[12] = mk(1, 6, 1, 1, 1, 6, 0, 0,          0, C_LU,   0);

    idle_in();
    p_rst = 1;
    tick(); tick();
    p_rst = 0;
    @(negedge p_clk);
    chk("reset.ctl", 64'(ctl_now()), 64'(C_IDLE));
    chk("reset.mepc", 64'(mepc), 64'(0));
    chk("reset.cause", 64'(cause), 64'(0));
    tick();

    for (int i = 0; i < 13; i++) begin
      idle_in();
      dec_ce = vecs[i].dec_ce; dec_rs1 = vecs[i].rs1; dec_rs2 = vecs[i].rs2;
      ex_ce = vecs[i].ex_ce; ex_load = vecs[i].ex_load; ex_rd = vecs[i].ex_rd;
      ex_redir = vecs[i].ex_redir; ex_target = vecs[i].ex_target; mem_busy = vecs[i].busy;
      expect_cycle($sformatf("vec%0d", i), vecs[i].exp_ctl, vecs[i].exp_pc);
      tick();
    end
    idle_in();
    expect_cycle("after_table", C_IDLE, 0);
    tick();

    // ECALL: redirect to trap vector three cycles later; stale branch in DRAIN ignored.
    raise_exc(4'b0010, 32'h20);
    expect_cycle("ecall.drain1", C_DRAIN, 0);
    chk("ecall.mepc", 64'(mepc), 64'h20);
    chk("ecall.cause", 64'(cause), 64'(1));
    tick();
    ex_redir = 1; ex_target = 32'h99;
    expect_cycle("ecall.drain2", C_DRAIN, 0);
    tick(); idle_in();
    expect_cycle("ecall.trap", C_RDIR, 32'h100);
    tick();
    expect_cycle("ecall.run", C_IDLE, 0);
    tick();

    // ILLEGAL+EBREAK with mem_busy for two DRAIN cycles: lowest bit wins, redirect delayed.
    raise_exc(4'b0101, 32'h24);
    mem_busy = 1;
    expect_cycle("busy.d1", C_DBUSY, 0);
    tick();
    expect_cycle("busy.d2", C_DBUSY, 0);
    tick(); mem_busy = 0;
    expect_cycle("busy.d3", C_DRAIN, 0);
    tick();
    expect_cycle("busy.d4", C_DRAIN, 0);
    tick();
    expect_cycle("busy.trap", C_RDIR, 32'h100);
    chk("busy.cause", 64'(cause), 64'(0));
    chk("busy.mepc", 64'(mepc), 64'h24);
    tick();

    // EBREAK: no redirect, HALT until resume, then mepc+4.
    raise_exc(4'b0100, 32'h30);
    tick(); tick();
    expect_cycle("ebreak.trap", C_IDLE, 0);
    tick();
    expect_cycle("ebreak.halt1", C_HALT, 0);
    chk("ebreak.cause", 64'(cause), 64'(2));
    tick();
    expect_cycle("ebreak.halt2", C_HALT, 0);
    tick();
    resume = 1;
    expect_cycle("ebreak.resume", C_RESUM, 32'h34);
    tick(); idle_in();
    expect_cycle("ebreak.run", C_IDLE, 0);
    tick();

    // MRET near the top of the address space: mepc+4 wraps to 0.
    raise_exc(4'b1000, 32'hFFFF_FFFC);
    tick(); tick();
    expect_cycle("mret.trap", C_RDIR, 32'h0);
    chk("mret.cause", 64'(cause), 64'(3));
    tick();

    // Reset in the middle of DRAIN abandons the trap.
    raise_exc(4'b0010, 32'h50);
    tick();
    p_rst = 1;
    tick();
    p_rst = 0;
    expect_cycle("rst.c0", C_IDLE, 0);
    chk("rst.mepc", 64'(mepc), 64'(0));
    chk("rst.cause", 64'(cause), 64'(0));
`ifdef PIPE_CTRL_PERF_EN
    chk("rst.perf", {perf_stall, perf_flush | perf_trap}, 64'(0));
`endif
    tick();
    expect_cycle("rst.c1", C_IDLE, 0);
    tick();
    expect_cycle("rst.c2", C_IDLE, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
